// File: rtl/otbn_rf_bignum_wipe.sv
// Wipes the bignum register file: one pass of URND data into every WDR, optionally
// followed by a pass of integrity-valid zeros (macro OTBN_RF_BIGNUM_WIPE_ZERO_PASS_EN).
module otbn_rf_bignum_wipe #(
  parameter int NWdr    = 32,
  parameter int WLEN    = 256,
  parameter int ExtWLEN = 312
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                urnd_valid_i,
  input  logic [WLEN-1:0]     urnd_data_i,
  output logic                urnd_ack_o,
  output logic [4:0]          wr_addr_o,
  output logic [7:0]          wr_en_o,
  output logic                wr_commit_o,
  output logic [WLEN-1:0]     wr_data_no_intg_o,
  output logic [ExtWLEN-1:0]  wr_data_intg_o,
  output logic                wr_data_intg_sel_o,
  output logic [NWdr-1:0]     rf_we_onehot_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o
);

  localparam logic [4:0] LastIdx = 5'(NWdr - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RND  = 2'd1,
`ifdef OTBN_RF_BIGNUM_WIPE_ZERO_PASS_EN
    ZERO = 2'd2,
`endif
    DONE = 2'd3
  } state_e;

  state_e     state_reg;
  logic [4:0] cnt_reg;
  logic       rnd_wr;
  logic       wr_any;
  logic       wiping;

  // Abort wins over the pending write so a half-consumed URND word is never used.
  assign rnd_wr = (state_reg == RND) && urnd_valid_i && !abort_i;

`ifdef OTBN_RF_BIGNUM_WIPE_ZERO_PASS_EN
  localparam logic [38:0] SecdedInv3932ZeroWord = 39'h2A00000000;
  logic zero_wr;

  assign zero_wr = (state_reg == ZERO) && !abort_i;
  assign wr_any  = rnd_wr || zero_wr;
  assign wiping  = (state_reg == RND) || (state_reg == ZERO);
  assign wr_data_intg_sel_o = zero_wr;

  for (genvar gi = 0; gi < ExtWLEN / 39; gi++) begin : g_intg
    assign wr_data_intg_o[gi*39 +: 39] = zero_wr ? SecdedInv3932ZeroWord : 39'd0;
  end
`else
  assign wr_any  = rnd_wr;
  assign wiping  = (state_reg == RND);
  assign wr_data_intg_sel_o = 1'b0;
  assign wr_data_intg_o     = '0;
`endif

  assign urnd_ack_o        = rnd_wr;
  assign wr_en_o           = {8{wr_any}};
  assign wr_commit_o       = wr_any;
  assign wr_addr_o         = wr_any ? cnt_reg : 5'd0;
  assign wr_data_no_intg_o = rnd_wr ? urnd_data_i : '0;
  assign busy_o            = (state_reg != IDLE);
  assign done_o            = (state_reg == DONE);
  assign aborted_o         = wiping && abort_i;

  for (genvar gi = 0; gi < NWdr; gi++) begin : g_onehot
    assign rf_we_onehot_o[gi] = wr_any && (cnt_reg == 5'(gi));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 5'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= 5'd0;
          if (start_i && !abort_i) state_reg <= RND;
        end
        RND: begin
          if (abort_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
          end else if (urnd_valid_i) begin
            if (cnt_reg == LastIdx) begin
              cnt_reg <= 5'd0;
`ifdef OTBN_RF_BIGNUM_WIPE_ZERO_PASS_EN
              state_reg <= ZERO;
`else
              state_reg <= DONE;
`endif
            end else begin
              cnt_reg <= cnt_reg + 5'd1;
            end
          end
        end
`ifdef OTBN_RF_BIGNUM_WIPE_ZERO_PASS_EN
        ZERO: begin
          if (abort_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
          end else if (cnt_reg == LastIdx) begin
            state_reg <= DONE;
            cnt_reg   <= 5'd0;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
`endif
        DONE: begin
          state_reg <= IDLE;
          cnt_reg   <= 5'd0;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= 5'd0;
        end
      endcase
    end
  end

endmodule
